// File: rtl/uart_pkg.sv
// Shared definitions for the jacaranda-8 UART: state encodings, frame
// constants and divisor clamping. The parity variant (UART_TX_PARITY_EN)
// widens the state encoding to make room for the PARITY state.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS = 8;
    localparam logic [31:0] UART_MIN_DIV   = 32'd2;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'b000,
        START  = 3'b001,
        DATA   = 3'b011,
        STOP   = 3'b010,
        PARITY = 3'b110
    } uart_state_e;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b11,
        STOP  = 2'b10
    } uart_state_e;
`endif

    // Divisors below the minimum would give a zero-length bit; force them up.
    function automatic logic [31:0] clamp_div(input logic [31:0] d);
        return (d < UART_MIN_DIV) ? UART_MIN_DIV : d;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// CPU-side and line-side signals of the UART transmitter.
// master: the CPU/bench that writes bytes; slave: the transmitter.
interface uart_tx_if;

    logic [31:0]                          clk_count_bit;
    logic                                 tx_en;
    logic                                 wr_en;
    logic [uart_pkg::UART_DATA_BITS-1:0]  wr_data;
    logic                                 full;
    logic                                 busy;
    logic                                 tx;
    logic                                 end_flag;

    modport master (
        output clk_count_bit, tx_en, wr_en, wr_data,
        input  full, busy, tx, end_flag
    );

    modport slave (
        input  clk_count_bit, tx_en, wr_en, wr_data,
        output full, busy, tx, end_flag
    );

endinterface

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: latches a clamped divisor on load and flags the last
// clock of each bit. Shared between tx and a future rx rewrite.
module uart_baud_cnt
    import uart_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        load,
    input  logic [31:0] div_in,
    output logic        bit_end
);

    logic [31:0] div_q, div_d;
    logic [31:0] clk_cnt_q, clk_cnt_d;

    assign bit_end = (clk_cnt_q == div_q - 32'd1);

    // Next counter/divisor: load restarts a bit with a fresh divisor.
    always_comb begin
        div_d     = div_q;
        clk_cnt_d = clk_cnt_q + 32'd1;
        if (load) begin
            div_d     = clamp_div(div_in);
            clk_cnt_d = '0;
        end else if (clear || bit_end) begin
            clk_cnt_d = '0;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q     <= '0;
            clk_cnt_q <= '0;
        end else begin
            div_q     <= div_d;
            clk_cnt_q <= clk_cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// Double-buffered 8N1 UART transmitter (8E1 when UART_TX_PARITY_EN is
// defined). A one-byte holding register feeds the shifter so the next byte
// can be queued while a frame is on the wire.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter logic        IDLE_LEVEL = 1'b1
) (
    input  logic     clk,
    input  logic     rst,
    uart_tx_if.slave bus
);

    if (DATA_BITS != UART_DATA_BITS) begin : g_bad_width
        $error("uart_tx supports only 8 data bits");
    end

    localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

    uart_state_e state_q, state_d;
    logic [7:0]  hold_q, hold_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic        full_q, full_d;
    logic        tx_q, tx_d;
    logic        end_q, end_d;
`ifdef UART_TX_PARITY_EN
    logic        parity_q, parity_d;
`endif

    logic load;
    logic bit_end;
    logic start_ok;

    assign start_ok = full_q && bus.tx_en;

    uart_baud_cnt u_baud (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_q == IDLE),
        .load    (load),
        .div_in  (bus.clk_count_bit),
        .bit_end (bit_end)
    );

    // Frame sequencing, holding-register write/drain and line level.
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        full_d    = full_q;
        tx_d      = tx_q;
        end_d     = 1'b0;
        load      = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif

        case (state_q)
            IDLE: begin
                tx_d = IDLE_LEVEL;
                if (start_ok) load = 1'b1;
            end
            START: begin
                if (bit_end) begin
                    tx_d    = shift_q[0];
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_cnt_q != LAST_BIT) begin
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end else begin
`ifdef UART_TX_PARITY_EN
                        tx_d    = parity_q;
                        state_d = PARITY;
`else
                        tx_d    = IDLE_LEVEL;
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    tx_d    = IDLE_LEVEL;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    end_d = 1'b1;
                    if (start_ok) load = 1'b1;
                    else          state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Frame start from IDLE or directly out of STOP (back-to-back).
        if (load) begin
            shift_d   = hold_q;
            full_d    = 1'b0;
            tx_d      = ~IDLE_LEVEL;
            bit_cnt_d = '0;
            state_d   = START;
`ifdef UART_TX_PARITY_EN
            parity_d  = ^hold_q;
`endif
        end

        // load needs full_q=1, so it never coincides with an accepted write.
        if (bus.wr_en && !full_q) begin
            hold_d = bus.wr_data;
            full_d = 1'b1;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            hold_q    <= '0;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            full_q    <= 1'b0;
            tx_q      <= IDLE_LEVEL;
            end_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            full_q    <= full_d;
            tx_q      <= tx_d;
            end_q     <= end_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign bus.full     = full_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.tx       = tx_q;
    assign bus.end_flag = end_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx. Expected line levels come from a frame
// model (start, data LSB first, optional parity, stop) indexed by clock.
module tb_uart_tx;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_tx_if bus ();

    uart_tx #(.DATA_BITS(8), .IDLE_LEVEL(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    int         n_checks = 0;
    int         n_err    = 0;
    bit         model_full;
    logic [7:0] model_hold;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int eff_div(input logic [31:0] d);
        return (d < 2) ? 2 : int'(d);
    endfunction

    // Line level of frame bit i for byte b.
    function automatic logic frame_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
`ifdef UART_TX_PARITY_EN
        if (i == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // Record a write in the model and apply it for one edge.
    task automatic write(input logic [7:0] b);
        bus.wr_en   = 1'b1;
        bus.wr_data = b;
        if (!model_full) begin
            model_full = 1'b1;
            model_hold = b;
        end
        tick;
        bus.wr_en = 1'b0;
    endtask

    // Checks one whole frame starting at the next edge. Optional writes at
    // clock k1/k2; scramble changes the divisor and drops tx_en mid-frame.
    task automatic frame(input logic [7:0] b, input int d, input bit end_first,
                         input bit scramble, input int k1, input logic [7:0] b1,
                         input int k2, input logic [7:0] b2);
        model_full = 1'b0;
        for (int k = 0; k < NBITS * d; k++) begin
            if (k == k1 || k == k2) begin
                bus.wr_en   = 1'b1;
                bus.wr_data = (k == k1) ? b1 : b2;
            end
            tick;
            if (bus.wr_en && !model_full) begin
                model_full = 1'b1;
                model_hold = bus.wr_data;
            end
            bus.wr_en = 1'b0;
            if (scramble && k == 0) begin
                bus.clk_count_bit = $urandom_range(0, 40);
                bus.tx_en         = 1'b0;
            end
            chk("tx", {31'd0, bus.tx}, {31'd0, frame_bit(b, k / d)});
            chk("end_flag", {31'd0, bus.end_flag}, {31'd0, (k == 0) && end_first});
            chk("busy", {31'd0, bus.busy}, 32'd1);
            chk("full", {31'd0, bus.full}, {31'd0, model_full});
        end
        bus.tx_en = 1'b1;
    endtask

    task automatic after_frame;
        tick;
        chk("end_pulse", {31'd0, bus.end_flag}, 32'd1);
        chk("idle_tx", {31'd0, bus.tx}, 32'd1);
        chk("idle_busy", {31'd0, bus.busy}, 32'd0);
        tick;
        chk("end_once", {31'd0, bus.end_flag}, 32'd0);
    endtask

    initial begin
        logic [7:0] b;
        int         d;

        rst               = 1'b1;
        bus.clk_count_bit = 32'd16;
        bus.tx_en         = 1'b0;
        bus.wr_en         = 1'b0;
        bus.wr_data       = '0;
        model_full        = 1'b0;
        model_hold        = '0;
        repeat (3) tick;
        chk("rst_tx", {31'd0, bus.tx}, 32'd1);
        chk("rst_full", {31'd0, bus.full}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_end", {31'd0, bus.end_flag}, 32'd0);
        rst = 1'b0;
        tick;

        // A5 at 16 clocks per bit; divisor and tx_en disturbed mid-frame.
        bus.tx_en = 1'b1;
        write(8'hA5);
        chk("wr_full", {31'd0, bus.full}, 32'd1);
        chk("wr_tx", {31'd0, bus.tx}, 32'd1);
        frame(8'hA5, 16, 1'b0, 1'b1, -1, 8'h00, -1, 8'h00);
        after_frame();

        // Back-to-back: 81 queued mid-frame, EE dropped while full.
        d = $urandom_range(2, 6);
        bus.clk_count_bit = d;
        write(8'h3C);
        frame(8'h3C, d, 1'b0, 1'b0, 3, 8'h81, 5, 8'hEE);
        frame(model_hold, d, 1'b1, 1'b0, -1, 8'h00, -1, 8'h00);
        chk("b2b_second", {24'd0, model_hold}, 32'h81);
        after_frame();
        chk("b2b_drained", {31'd0, bus.full}, 32'd0);

        // tx_en low holds a queued byte.
        bus.tx_en = 1'b0;
        bus.clk_count_bit = 32'd5;
        write(8'h42);
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("hold_tx", {31'd0, bus.tx}, 32'd1);
            chk("hold_full", {31'd0, bus.full}, 32'd1);
            chk("hold_busy", {31'd0, bus.busy}, 32'd0);
        end
        bus.tx_en = 1'b1;
        frame(8'h42, 5, 1'b0, 1'b0, -1, 8'h00, -1, 8'h00);
        after_frame();

        // Reset in DATA bit 4 with a second byte queued.
        b = 8'($urandom);
        bus.clk_count_bit = 32'd4;
        write(b);
        repeat (3) tick;
        write(8'h99);
        repeat (19) tick;
        chk("pre_rst_tx", {31'd0, bus.tx}, {31'd0, frame_bit(b, 5)});
        chk("pre_rst_full", {31'd0, bus.full}, 32'd1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        model_full = 1'b0;
        chk("mid_rst_tx", {31'd0, bus.tx}, 32'd1);
        chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("mid_rst_full", {31'd0, bus.full}, 32'd0);
        chk("mid_rst_end", {31'd0, bus.end_flag}, 32'd0);
        for (int i = 0; i < 40; i++) begin
            tick;
            chk("post_rst_end", {31'd0, bus.end_flag}, 32'd0);
            chk("post_rst_tx", {31'd0, bus.tx}, 32'd1);
        end

        // Divisor clamp: 0 and 1 both give 2 clocks per bit.
        bus.clk_count_bit = 32'd0;
        write(8'h01);
        frame(8'h01, eff_div(0), 1'b0, 1'b0, -1, 8'h00, -1, 8'h00);
        after_frame();
        bus.clk_count_bit = 32'd1;
        write(8'h07);
        frame(8'h07, eff_div(1), 1'b0, 1'b0, -1, 8'h00, -1, 8'h00);
        after_frame();

        // Random bytes and divisors.
        for (int n = 0; n < 4; n++) begin
            d = $urandom_range(2, 7);
            b = 8'($urandom);
            bus.clk_count_bit = d;
            write(b);
            frame(b, d, 1'b0, 1'b1, -1, 8'h00, -1, 8'h00);
            after_frame();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
